prf_wb_arbiter: RTL and testbench

- Shares the PRF bank write ports among the PRF_WR_COUNT writeback requesters: ALU Reg-Reg, MDU, ALU Reg-Imm, BRU, LDU, STAMOFU, SYS.
- Each requester has a 1-entry holding buffer. Each bank grants at most one write per cycle using per-bank round-robin.
- Bank writes are registered, and per-bank writeback broadcasts for IQ wakeup are derived from them.
- Sits between the execute pipelines and the PRF banks.

---
 rtl/prf_wb_arbiter_pkg.sv | 22 ++
 rtl/rr_arbiter_onehot.sv | 33 +++
 rtl/prf_wb_arbiter.sv | 100 ++++++++++
 tb/tb_prf_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_wb_arbiter_pkg.sv
// Shared constants and types for the PRF writeback arbiter.
// Bank index is the low bits of the physical register tag.
package prf_wb_arbiter_pkg;

    localparam int PRF_WR_COUNT       = 7;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int LOG_PR_COUNT       = 7;
    localparam int XLEN               = 32;
    localparam int LOG_PRF_WR_COUNT   = $clog2(PRF_WR_COUNT);
    localparam int PRF_WB_LATENCY     = 2;

    typedef struct packed {
        logic [LOG_PR_COUNT-1:0] pr;
        logic [XLEN-1:0]         data;
    } wb_req_t;

    function automatic logic [LOG_PRF_BANK_COUNT-1:0] bank_of(input logic [LOG_PR_COUNT-1:0] pr);
        return pr[LOG_PRF_BANK_COUNT-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: first requester at or after ptr wins (wrapping).
// Pointer state is owned by the instantiating module.
module rr_arbiter_onehot #(
    parameter int WIDTH = 7,
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [WIDTH-1:0] grant,
    output logic [IDXW-1:0]  winner
);

    always_comb begin
        int               idx;
        logic [IDXW-1:0]  sel;
        grant  = '0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        // Scan from farthest to nearest so the nearest requester is assigned last.
        for (int k = WIDTH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= WIDTH) idx = idx - WIDTH;
            sel = IDXW'(idx);
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                winner     = sel;
            end
        end
    end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Shares PRF bank write ports among writeback requesters through 1-entry
// holding buffers and per-bank round-robin; bank writes are registered.
module prf_wb_arbiter
    import prf_wb_arbiter_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRF_WR_COUNT-1:0]   wr_req_valid_by_wr,
    input  logic [LOG_PR_COUNT-1:0]   wr_req_PR_by_wr   [PRF_WR_COUNT-1:0],
    input  logic [XLEN-1:0]           wr_req_data_by_wr [PRF_WR_COUNT-1:0],
    output logic [PRF_WR_COUNT-1:0]   wr_req_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0] bank_wr_valid_by_bank,
    output logic [LOG_PR_COUNT-1:0]   bank_wr_PR_by_bank   [PRF_BANK_COUNT-1:0],
    output logic [XLEN-1:0]           bank_wr_data_by_bank [PRF_BANK_COUNT-1:0],
    output logic [PRF_WR_COUNT-1:0]   bank_wr_src_by_bank  [PRF_BANK_COUNT-1:0]
);

    logic [PRF_WR_COUNT-1:0]     buf_valid;
    wb_req_t                     buf_q       [PRF_WR_COUNT-1:0];
    logic [LOG_PRF_WR_COUNT-1:0] ptr         [PRF_BANK_COUNT-1:0];
    logic [PRF_WR_COUNT-1:0]     bank_req    [PRF_BANK_COUNT-1:0];
    logic [PRF_WR_COUNT-1:0]     bank_grant  [PRF_BANK_COUNT-1:0];
    logic [LOG_PRF_WR_COUNT-1:0] bank_winner [PRF_BANK_COUNT-1:0];
    logic [PRF_WR_COUNT-1:0]     granted;

    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            bank_req[b] = '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                bank_req[b][i] = buf_valid[i] &&
                                 (bank_of(buf_q[i].pr) == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
        rr_arbiter_onehot #(.WIDTH(PRF_WR_COUNT)) u_arb (
            .req    (bank_req[b]),
            .ptr    (ptr[b]),
            .grant  (bank_grant[b]),
            .winner (bank_winner[b])
        );
    end

    // A requester maps to a single bank, so OR-ing bank grants never double-counts.
    always_comb begin
        granted = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            granted = granted | bank_grant[b];
        end
    end

    assign wr_req_ready_by_wr = ~buf_valid | granted;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            buf_valid <= '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (wr_req_valid_by_wr[i] && wr_req_ready_by_wr[i]) begin
                    buf_valid[i]  <= 1'b1;
                    buf_q[i].pr   <= wr_req_PR_by_wr[i];
                    buf_q[i].data <= wr_req_data_by_wr[i];
                end else if (granted[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_wr_valid_by_bank <= '0;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                ptr[b]                  <= '0;
                bank_wr_PR_by_bank[b]   <= '0;
                bank_wr_data_by_bank[b] <= '0;
                bank_wr_src_by_bank[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (|bank_grant[b]) begin
                    bank_wr_valid_by_bank[b] <= 1'b1;
                    bank_wr_PR_by_bank[b]    <= buf_q[bank_winner[b]].pr;
                    bank_wr_data_by_bank[b]  <= buf_q[bank_winner[b]].data;
                    bank_wr_src_by_bank[b]   <= bank_grant[b];
                    ptr[b] <= (bank_winner[b] == LOG_PRF_WR_COUNT'(PRF_WR_COUNT - 1))
                              ? '0 : bank_winner[b] + 1'b1;
                end else begin
                    bank_wr_valid_by_bank[b] <= 1'b0;
                    bank_wr_src_by_bank[b]   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: hand-computed expectations checked with
// immediate assertions, plus a monitor for the requester hold contract.
module tb_prf_wb_arbiter;
    import prf_wb_arbiter_pkg::*;

    logic                      CLK = 1'b0;
    logic                      RST;
    logic [PRF_WR_COUNT-1:0]   vld;
    logic [LOG_PR_COUNT-1:0]   pr_in   [PRF_WR_COUNT-1:0];
    logic [XLEN-1:0]           data_in [PRF_WR_COUNT-1:0];
    logic [PRF_WR_COUNT-1:0]   ready;
    logic [PRF_BANK_COUNT-1:0] bvalid;
    logic [LOG_PR_COUNT-1:0]   bpr   [PRF_BANK_COUNT-1:0];
    logic [XLEN-1:0]           bdata [PRF_BANK_COUNT-1:0];
    logic [PRF_WR_COUNT-1:0]   bsrc  [PRF_BANK_COUNT-1:0];

    int n_cmp = 0;
    int n_err = 0;

    prf_wb_arbiter dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .wr_req_valid_by_wr    (vld),
        .wr_req_PR_by_wr       (pr_in),
        .wr_req_data_by_wr     (data_in),
        .wr_req_ready_by_wr    (ready),
        .bank_wr_valid_by_bank (bvalid),
        .bank_wr_PR_by_bank    (bpr),
        .bank_wr_data_by_bank  (bdata),
        .bank_wr_src_by_bank   (bsrc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag, input int b, input logic v,
                            input logic [LOG_PR_COUNT-1:0] pr, input logic [XLEN-1:0] d,
                            input logic [PRF_WR_COUNT-1:0] src);
        check({tag, "_valid"}, 64'(bvalid[b]), 64'(v));
        check({tag, "_pr"},    64'(bpr[b]),    64'(pr));
        check({tag, "_data"},  64'(bdata[b]),  64'(d));
        check({tag, "_src"},   64'(bsrc[b]),   64'(src));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        vld = '0;
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            pr_in[i]   = '0;
            data_in[i] = '0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        tick();
        RST = 1'b0;
    endtask

    // Requester contract: while valid & !ready, valid/PR/data must not change.
    logic [PRF_WR_COUNT-1:0] hold_q = '0;
    logic [LOG_PR_COUNT-1:0] hold_pr   [PRF_WR_COUNT-1:0];
    logic [XLEN-1:0]         hold_data [PRF_WR_COUNT-1:0];

    always @(negedge CLK) begin
        if (RST) begin
            hold_q = '0;
        end else begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (hold_q[i]) begin
                    check("contract_valid", 64'(vld[i]), 64'(1'b1));
                    check("contract_pr",    64'(pr_in[i]), 64'(hold_pr[i]));
                    check("contract_data",  64'(data_in[i]), 64'(hold_data[i]));
                end
                hold_q[i]    = vld[i] & ~ready[i];
                hold_pr[i]   = pr_in[i];
                hold_data[i] = data_in[i];
            end
        end
    end

    int w, loser, n2, n4, g2, g4;
    logic [PRF_WR_COUNT-1:0] exp_rdy;

    initial begin
        RST = 1'b1;
        clear_inputs();
        #2;
        // Reset state.
        for (int b = 0; b < PRF_BANK_COUNT; b++) chk_bank("rst", b, 1'b0, '0, '0, '0);
        check("rst_ready", 64'(ready), 64'(7'h7F));
        tick();
        RST = 1'b0;

        // 1: single requester, PR 5 -> bank 1, visible two edges after hand-off.
        pr_in[0] = 7'd5; data_in[0] = 32'hDEAD_BEEF; vld[0] = 1'b1;
        check("t1_ready_pre", 64'(ready[0]), 64'(1'b1));
        tick();
        vld[0] = 1'b0;
        check("t1_ready_buf", 64'(ready), 64'(7'h7F));
        check("t1_not_yet", 64'(bvalid), 64'(4'h0));
        for (int i = 1; i < PRF_WB_LATENCY; i++) tick();
        chk_bank("t1_b1", 1, 1'b1, 7'd5, 32'hDEAD_BEEF, 7'b0000001);
        check("t1_b0_idle", 64'(bvalid[0]), 64'(1'b0));
        tick();
        chk_bank("t1_b1_after", 1, 1'b0, 7'd5, 32'hDEAD_BEEF, 7'b0000000);
        check("t1_ready_end", 64'(ready), 64'(7'h7F));

        // 2: requesters 2 and 4 streaming into bank 0 alternate 2,4,2,4.
        do_reset();
        n2 = 0; n4 = 0; g2 = 0; g4 = 0;
        vld[2] = 1'b1; pr_in[2] = 7'd8;  data_in[2] = 32'h2200_0000;
        vld[4] = 1'b1; pr_in[4] = 7'd12; data_in[4] = 32'h4400_0000;
        check("t2_ready_start", 64'(ready), 64'(7'h7F));
        tick();
        n2 = 1; n4 = 1;
        data_in[2] = 32'h2200_0000 + 32'(n2);
        data_in[4] = 32'h4400_0000 + 32'(n4);
        for (int k = 1; k <= 8; k++) begin
            w       = (k % 2 == 1) ? 2 : 4;
            loser   = 6 - w;
            exp_rdy = 7'h7F;
            exp_rdy[loser] = 1'b0;
            check($sformatf("t2_ready_k%0d", k), 64'(ready), 64'(exp_rdy));
            tick();
            if (w == 2) begin
                chk_bank($sformatf("t2_k%0d", k), 0, 1'b1, 7'd8, 32'h2200_0000 + 32'(g2), 7'b0000100);
                g2++; n2++;
                data_in[2] = 32'h2200_0000 + 32'(n2);
            end else begin
                chk_bank($sformatf("t2_k%0d", k), 0, 1'b1, 7'd12, 32'h4400_0000 + 32'(g4), 7'b0010000);
                g4++; n4++;
                data_in[4] = 32'h4400_0000 + 32'(n4);
            end
        end

        // 3: requesters 0..3 to four different banks in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b1; pr_in[i] = 7'(4 + i); data_in[i] = 32'h1000_0000 + 32'(i);
        end
        tick();
        vld = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_bank($sformatf("t3_b%0d", (4 + i) % 4), (4 + i) % 4, 1'b1, 7'(4 + i),
                     32'h1000_0000 + 32'(i), 7'(1 << i));
        end

        // 4: all seven requesters to bank 2, granted 0..6 in order.
        do_reset();
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            vld[i] = 1'b1; pr_in[i] = 7'(2 + 4 * i); data_in[i] = 32'hA000_0000 + 32'(i);
        end
        tick();
        vld = '0;
        for (int k = 0; k < PRF_WR_COUNT; k++) begin
            check($sformatf("t4_ready_k%0d", k), 64'(ready), 64'((8'd1 << (k + 1)) - 8'd1));
            tick();
            chk_bank($sformatf("t4_k%0d", k), 2, 1'b1, 7'(2 + 4 * k), 32'hA000_0000 + 32'(k), 7'(1 << k));
        end
        tick();
        check("t4_idle", 64'(bvalid), 64'(4'h0));
        // Pointer wrapped to 0: requester 0 beats requester 6.
        vld[6] = 1'b1; pr_in[6] = 7'd30; data_in[6] = 32'hB6;
        vld[0] = 1'b1; pr_in[0] = 7'd34; data_in[0] = 32'hB0;
        tick();
        vld = '0;
        tick();
        chk_bank("t4_wrap_first", 2, 1'b1, 7'd34, 32'hB0, 7'b0000001);
        tick();
        chk_bank("t4_wrap_second", 2, 1'b1, 7'd30, 32'hB6, 7'b1000000);

        // 5: losing buffered requester 5 holds a new request, then grant+refill.
        do_reset();
        vld[3] = 1'b1; pr_in[3] = 7'd9;  data_in[3] = 32'h0333_0000;
        vld[5] = 1'b1; pr_in[5] = 7'd13; data_in[5] = 32'h0555_000A;
        tick();
        vld[3] = 1'b0;
        check("t5_ready5_lose", 64'(ready[5]), 64'(1'b0));
        pr_in[5] = 7'd17; data_in[5] = 32'h0555_000B;
        tick();
        chk_bank("t5_first", 1, 1'b1, 7'd9, 32'h0333_0000, 7'b0001000);
        check("t5_ready5_grant", 64'(ready[5]), 64'(1'b1));
        tick();
        vld[5] = 1'b0;
        chk_bank("t5_old", 1, 1'b1, 7'd13, 32'h0555_000A, 7'b0100000);
        check("t5_ready5_refilled", 64'(ready[5]), 64'(1'b1));
        tick();
        chk_bank("t5_new", 1, 1'b1, 7'd17, 32'h0555_000B, 7'b0100000);
        tick();
        check("t5_idle", 64'(bvalid[1]), 64'(1'b0));

        // 6: asynchronous reset with three buffers loaded.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b1; pr_in[i] = 7'(3 + 4 * i); data_in[i] = 32'hC000_0000 + 32'(i);
        end
        tick();
        vld = '0;
        tick();
        chk_bank("t6_pre", 3, 1'b1, 7'd3, 32'hC000_0000, 7'b0000001);
        #1;
        RST = 1'b1;
        #1;
        for (int b = 0; b < PRF_BANK_COUNT; b++) chk_bank("t6_async", b, 1'b0, '0, '0, '0);
        check("t6_ready_rst", 64'(ready), 64'(7'h7F));
        #1;
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_no_write_k%0d", k), 64'(bvalid), 64'(4'h0));
            check($sformatf("t6_ready_k%0d", k), 64'(ready), 64'(7'h7F));
        end
        // Pointer of bank 3 is back at 0: requester 0 beats requester 1.
        vld[1] = 1'b1; pr_in[1] = 7'd7; data_in[1] = 32'hD1;
        vld[0] = 1'b1; pr_in[0] = 7'd3; data_in[0] = 32'hD0;
        tick();
        vld = '0;
        check("t6_ptr_ready", 64'(ready), 64'(7'b1111101));
        tick();
        chk_bank("t6_ptr", 3, 1'b1, 7'd3, 32'hD0, 7'b0000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
